// File: rtl/fifo_uart_tx.sv
// rtl/fifo_uart_tx.sv - pops 16-bit words from an upstream FIFO and sends them as two 8N1 bytes, high byte first
module fifo_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        fifo_empty,
  input  logic [15:0] fifo_dout,
  input  logic        fifo_valid,
  output logic        fifo_rd,
  output logic        txd,
  output logic        busy,
  output logic [15:0] words_sent
);

  typedef enum logic [2:0] {IDLE, FETCH, START, DATA, STOP} state_t;

  localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);

  state_t      state_q;
  logic        txd_q;
  logic        rd_q;
  logic        busy_q;
  logic [15:0] words_q;
  logic [15:0] baud_q;
  logic [2:0]  bit_q;
  logic        second_q;
  logic [15:0] shift_q;

  logic baud_done;
  assign baud_done = (baud_q == BAUD_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      txd_q    <= 1'b1;
      rd_q     <= 1'b0;
      busy_q   <= 1'b0;
      words_q  <= 16'h0000;
      baud_q   <= 16'h0000;
      bit_q    <= 3'd0;
      second_q <= 1'b0;
      shift_q  <= 16'h0000;
    end else begin
      rd_q <= 1'b0;
      case (state_q)
        IDLE: begin
          txd_q  <= 1'b1;
          baud_q <= 16'h0000;
          if (en && !fifo_empty) begin
            state_q <= FETCH;
            rd_q    <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        FETCH: begin
          // Bytes are swapped on capture so a plain LSB-first shift emits the high byte first.
          if (fifo_valid) begin
            shift_q  <= {fifo_dout[7:0], fifo_dout[15:8]};
            state_q  <= START;
            txd_q    <= 1'b0;
            baud_q   <= 16'h0000;
            bit_q    <= 3'd0;
            second_q <= 1'b0;
          end
        end
        START: begin
          if (baud_done) begin
            state_q <= DATA;
            baud_q  <= 16'h0000;
            txd_q   <= shift_q[0];
          end else begin
            baud_q <= baud_q + 16'd1;
          end
        end
        DATA: begin
          if (baud_done) begin
            baud_q  <= 16'h0000;
            shift_q <= {1'b0, shift_q[15:1]};
            if (bit_q == 3'd7) begin
              state_q <= STOP;
              bit_q   <= 3'd0;
              txd_q   <= 1'b1;
            end else begin
              bit_q <= bit_q + 3'd1;
              txd_q <= shift_q[1];
            end
          end else begin
            baud_q <= baud_q + 16'd1;
          end
        end
        STOP: begin
          if (baud_done) begin
            baud_q <= 16'h0000;
            if (!second_q) begin
              second_q <= 1'b1;
              state_q  <= START;
              txd_q    <= 1'b0;
            end else begin
              second_q <= 1'b0;
              state_q  <= IDLE;
              busy_q   <= 1'b0;
              words_q  <= words_q + 16'd1;
              txd_q    <= 1'b1;
            end
          end else begin
            baud_q <= baud_q + 16'd1;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          txd_q   <= 1'b1;
        end
      endcase
    end
  end

  assign fifo_rd    = rd_q;
  assign txd        = txd_q;
  assign busy       = busy_q;
  assign words_sent = words_q;

endmodule
